msrh_lsu_replay_sel: RTL and testbench

//  Queue-side transmitter of the lsu_replay_if protocol. Sits inside LDQ/STQ and picks one

---
 rtl/msrh_lsu_replay_sel.sv | 105 ++++++++++
 tb/tb_msrh_lsu_replay_sel.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrh_lsu_replay_sel.sv
// Replay selector: picks the oldest replay-ready queue entry (scanning from the head)
// and presents it to the LSU pipe, holding it stable across LSU conflicts.
package msrh_pkg;
    typedef struct packed {
        logic [3:0]  op;
        logic [7:0]  rob_id;
        logic [31:0] inst;
    } issue_t;
endpackage

module msrh_lsu_replay_sel
    import msrh_pkg::*;
#(
    parameter int ENTRY_SIZE = 16,
    parameter int IDX_W      = $clog2(ENTRY_SIZE)
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic   [ENTRY_SIZE-1:0]        i_entry_ready,
    input  issue_t [ENTRY_SIZE-1:0]        i_entry_issue,
    input  logic   [ENTRY_SIZE-1:0]        i_entry_kill,
    input  logic   [IDX_W-1:0]             i_head_idx,
    output logic                           o_replay_valid,
    output issue_t                         o_replay_issue,
    output logic   [ENTRY_SIZE-1:0]        o_replay_index_oh,
    input  logic                           i_replay_conflict,
    output logic   [ENTRY_SIZE-1:0]        o_accept_oh,
    output logic   [15:0]                  o_stall_cnt
);

    logic                  r_valid;
    issue_t                r_issue;
    logic [ENTRY_SIZE-1:0] r_index_oh;
    logic [15:0]           r_stall_cnt;

    logic                  killed;
    logic                  take;
    logic                  repick;
    logic                  hold;
    logic [ENTRY_SIZE-1:0] excl;
    logic [ENTRY_SIZE-1:0] cand;
    logic                  pick_found;
    logic [IDX_W-1:0]      pick_idx;
    logic [ENTRY_SIZE-1:0] pick_oh;
    issue_t                pick_issue;
    int                    scan_pos;

    assign killed         = r_valid & |(r_index_oh & i_entry_kill);
    assign o_replay_valid = r_valid & ~killed;
    assign take           = o_replay_valid & ~i_replay_conflict;
    assign hold           = o_replay_valid & i_replay_conflict;
    // A presented entry leaving (taken or killed) is excluded so its stale ready bit can't re-win.
    assign repick         = ~r_valid | take | killed;
    assign excl           = (take | killed) ? r_index_oh : '0;
    assign cand           = i_entry_ready & ~i_entry_kill & ~excl;

    assign o_accept_oh       = take ? r_index_oh : '0;
    assign o_replay_issue    = r_issue;
    assign o_replay_index_oh = r_index_oh;
    assign o_stall_cnt       = r_stall_cnt;

    // Oldest-first scan from the head; explicit modular wrap supports non power-of-2 sizes.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_pos   = 0;
        for (int k = 0; k < ENTRY_SIZE; k++) begin
            scan_pos = int'(i_head_idx) + k;
            if (scan_pos >= ENTRY_SIZE) scan_pos = scan_pos - ENTRY_SIZE;
            if (!pick_found && cand[IDX_W'(scan_pos)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(scan_pos);
            end
        end
    end

    always_comb begin
        pick_oh = '0;
        if (pick_found) pick_oh[pick_idx] = 1'b1;
        pick_issue = i_entry_issue[pick_idx];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid    <= 1'b0;
            r_issue    <= '0;
            r_index_oh <= '0;
        end else if (repick) begin
            r_valid <= pick_found;
            if (pick_found) begin
                r_issue    <= pick_issue;
                r_index_oh <= pick_oh;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_stall_cnt <= '0;
        end else if (hold && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_msrh_lsu_replay_sel.sv
// Bench for msrh_lsu_replay_sel: directed table, hand-written corner sequences,
// and randomized traffic checked against an index-level reference model.
module tb_msrh_lsu_replay_sel;
    import msrh_pkg::*;

    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   ready;
    logic [N-1:0]   kill;
    issue_t [N-1:0] pay;
    logic [3:0]     head;
    logic           conflict;
    logic           valid;
    issue_t         r_issue;
    logic [N-1:0]   oh;
    logic [N-1:0]   acc;
    logic [15:0]    stall;

    int n_vec = 0;
    int n_err = 0;

    // reference model state: which entry is presented, what was latched
    bit     m_valid;
    int     m_idx;
    issue_t m_issue;
    int     m_stall;

    always #5 clk = ~clk;

    msrh_lsu_replay_sel #(.ENTRY_SIZE(N)) dut (
        .i_clk             (clk),
        .i_reset_n         (rst_n),
        .i_entry_ready     (ready),
        .i_entry_issue     (pay),
        .i_entry_kill      (kill),
        .i_head_idx        (head),
        .o_replay_valid    (valid),
        .o_replay_issue    (r_issue),
        .o_replay_index_oh (oh),
        .i_replay_conflict (conflict),
        .o_accept_oh       (acc),
        .o_stall_cnt       (stall)
    );

    typedef struct {
        logic [N-1:0] ready;
        logic [3:0]   head;
        logic         conf;
        logic         ev;
        logic [N-1:0] eoh;
        logic [N-1:0] eacc;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic issue_t mk_pay(input int i, input int salt);
        issue_t p;
        p.op     = 4'(i);
        p.rob_id = 8'(i * 7 + salt);
        p.inst   = 32'(32'hA500_0000 + i * 16 + salt);
        return p;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_idx   = 0;
        m_issue = '0;
        m_stall = 0;
    endtask

    // Called just after a negedge with inputs already driven.
    task automatic check_outputs();
        bit           m_killed;
        bit           ev;
        logic [N-1:0] eacc;
        #1;
        m_killed = m_valid && kill[m_idx];
        ev       = m_valid && !m_killed;
        eacc     = (ev && !conflict) ? (N'(1) << m_idx) : '0;
        chk("valid", 64'(valid), 64'(ev));
        chk("accept_oh", 64'(acc), 64'(eacc));
        chk("stall_cnt", 64'(stall), 64'(m_stall));
        if (ev) begin
            chk("index_oh", 64'(oh), 64'(N'(1) << m_idx));
            chk("issue", 64'(r_issue), 64'(m_issue));
        end
    endtask

    task automatic advance();
        int  excl;
        bit  found;
        int  idx;
        @(posedge clk);
        if (m_valid && !kill[m_idx] && conflict) begin
            if (m_stall < 65535) m_stall++;
        end else begin
            excl  = m_valid ? m_idx : -1;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = (int'(head) + k) % N;
                if (!found && ready[idx] && !kill[idx] && idx != excl) begin
                    found   = 1'b1;
                    m_idx   = idx;
                    m_issue = pay[idx];
                end
            end
            m_valid = found;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        ready    = '0;
        kill     = '0;
        head     = '0;
        conflict = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        chk("rst.valid", 64'(valid), 64'(0));
        chk("rst.index_oh", 64'(oh), 64'(0));
        chk("rst.accept_oh", 64'(acc), 64'(0));
        chk("rst.stall_cnt", 64'(stall), 64'(0));
        chk("rst.issue", 64'(r_issue), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) pay[i] = mk_pay(i, 0);

        //            ready     head   conf  ev    eoh       eacc
        tbl[0] = '{16'h0010, 4'd0,  1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[1] = '{16'h0010, 4'd0,  1'b0, 1'b1, 16'h0010, 16'h0010};
        tbl[2] = '{16'h0000, 4'd0,  1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[3] = '{16'h4003, 4'd14, 1'b0, 1'b0, 16'h0000, 16'h0000};
        tbl[4] = '{16'h4003, 4'd14, 1'b0, 1'b1, 16'h4000, 16'h4000};
        tbl[5] = '{16'h0003, 4'd14, 1'b0, 1'b1, 16'h0001, 16'h0001};
        tbl[6] = '{16'h0002, 4'd14, 1'b0, 1'b1, 16'h0002, 16'h0002};
        tbl[7] = '{16'h0000, 4'd14, 1'b0, 1'b0, 16'h0000, 16'h0000};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            ready    = tbl[i].ready;
            head     = tbl[i].head;
            conflict = tbl[i].conf;
            kill     = '0;
            check_outputs();
            chk($sformatf("tbl%0d.valid", i), 64'(valid), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d.accept_oh", i), 64'(acc), 64'(tbl[i].eacc));
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d.index_oh", i), 64'(oh), 64'(tbl[i].eoh));
                chk($sformatf("tbl%0d.issue", i), 64'(r_issue), 64'(pay[$clog2(tbl[i].eoh)]));
            end
            advance();
        end

        // hold under conflict, no re-arbitration towards the older entry
        do_reset();
        head  = 4'd2;
        ready = 16'h0008;
        check_outputs();
        advance();
        ready    = 16'h000C;
        conflict = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_outputs();
            chk("hold.index_oh", 64'(oh), 64'(16'h0008));
            advance();
        end
        conflict = 1'b0;
        check_outputs();
        chk("hold.stall_cnt", 64'(stall), 64'(5));
        chk("hold.accept3", 64'(acc), 64'(16'h0008));
        advance();
        ready = 16'h0004;
        check_outputs();
        chk("hold.next_oh", 64'(oh), 64'(16'h0004));
        chk("hold.accept2", 64'(acc), 64'(16'h0004));
        advance();
        ready = '0;
        check_outputs();
        advance();

        // kill of the presented entry: dropped, next younger candidate picked
        do_reset();
        head  = 4'd7;
        ready = 16'h0280;
        check_outputs();
        advance();
        kill = 16'h0080;
        check_outputs();
        chk("kill.valid", 64'(valid), 64'(0));
        chk("kill.accept_oh", 64'(acc), 64'(0));
        advance();
        kill  = '0;
        ready = 16'h0200;
        check_outputs();
        chk("kill.repick_valid", 64'(valid), 64'(1));
        chk("kill.repick_oh", 64'(oh), 64'(16'h0200));
        advance();
        ready = 16'h0080;
        check_outputs();
        advance();
        kill = 16'h0080;
        check_outputs();
        advance();
        kill  = '0;
        ready = '0;
        check_outputs();
        chk("kill.idle_valid", 64'(valid), 64'(0));
        advance();

        // async reset while presenting
        ready    = 16'h0020;
        head     = 4'd0;
        conflict = 1'b1;
        check_outputs();
        advance();
        check_outputs();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("areset.valid", 64'(valid), 64'(0));
        chk("areset.accept_oh", 64'(acc), 64'(0));
        chk("areset.index_oh", 64'(oh), 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        conflict = 1'b0;
        check_outputs();
        advance();
        check_outputs();
        chk("areset.repick_valid", 64'(valid), 64'(1));
        chk("areset.repick_oh", 64'(oh), 64'(16'h0020));
        ready = '0;
        advance();

        // stall counter saturation
        do_reset();
        ready = 16'h0001;
        check_outputs();
        advance();
        conflict = 1'b1;
        for (int i = 0; i < 70000; i++) advance();
        check_outputs();
        chk("sat.stall_cnt", 64'(stall), 64'(16'hFFFF));
        advance();
        check_outputs();
        chk("sat.stall_hold", 64'(stall), 64'(16'hFFFF));
        conflict = 1'b0;
        ready    = '0;
        advance();

        // randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            ready = N'($urandom) & N'($urandom);
            if ($urandom_range(0, 9) == 0) ready = '0;
            kill = '0;
            if ($urandom_range(0, 7) == 0) kill[$urandom_range(0, N - 1)] = 1'b1;
            if (m_valid && $urandom_range(0, 9) == 0) kill[m_idx] = 1'b1;
            if ($urandom_range(0, 3) == 0) head = 4'($urandom_range(0, N - 1));
            conflict = ($urandom_range(0, 99) < 40);
            if ($urandom_range(0, 3) == 0) pay[$urandom_range(0, N - 1)] = issue_t'($urandom);
            check_outputs();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
